// File: rtl/alu_pipe_pkg.sv
// rtl/alu_pipe_pkg.sv - shared field widths, instruction layout and bubble defaults
package alu_pipe_pkg;

  localparam int REG_W   = 4;
  localparam int FUNC_W  = 4;
  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 24;

  localparam int FUNC_LSB = 20;
  localparam int RD_LSB   = 16;
  localparam int RS1_LSB  = 12;
  localparam int RS2_LSB  = 8;
  localparam int ADDR_LSB = 0;

  localparam logic [FUNC_W-1:0] BUBBLE_FUNC_DEF = 4'hF;
  localparam logic [ADDR_W-1:0] BUBBLE_ADDR_DEF = 8'hFF;

  // Field order mirrors the packed in_instr layout, so a plain cast unpacks it.
  typedef struct packed {
    logic [FUNC_W-1:0] func;
    logic [REG_W-1:0]  rd;
    logic [REG_W-1:0]  rs1;
    logic [REG_W-1:0]  rs2;
    logic [ADDR_W-1:0] addr;
  } instr_t;

endpackage

// File: rtl/alu_issue_queue_if.sv
// rtl/alu_issue_queue_if.sv - instruction intake handshake plus issue bus towards pipeline_alu
interface alu_issue_queue_if;
  import alu_pipe_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [INSTR_W-1:0] in_instr;
  logic [REG_W-1:0]   rs1;
  logic [REG_W-1:0]   rs2;
  logic [REG_W-1:0]   rd;
  logic [FUNC_W-1:0]  func;
  logic [ADDR_W-1:0]  addr;
  logic               issue_valid;

  modport master (
    output in_valid, in_instr,
    input  in_ready, rs1, rs2, rd, func, addr, issue_valid
  );

  modport slave (
    input  in_valid, in_instr,
    output in_ready, rs1, rs2, rd, func, addr, issue_valid
  );

endinterface

// File: rtl/alu_instr_fifo.sv
// rtl/alu_instr_fifo.sv - DEPTH x W FIFO with push/pop/flush and occupancy count
module alu_instr_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 24
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  input  logic [W-1:0]           wdata_i,
  output logic [W-1:0]           rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem[rd_ptr_q];

  // Full blocks a push even when a pop frees a slot on the same edge.
  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/alu_issue_queue.sv
// rtl/alu_issue_queue.sv - buffered ALU issue with RAW hazard bubbles
// Feeds pipeline_alu one instruction per clock; it has no valid input, so bubbles must be harmless.
module alu_issue_queue
  import alu_pipe_pkg::*;
#(
  parameter int                DEPTH       = 4,
  parameter int                HAZ_WINDOW  = 3,
  parameter logic [FUNC_W-1:0] BUBBLE_FUNC = BUBBLE_FUNC_DEF,
  parameter logic [ADDR_W-1:0] BUBBLE_ADDR = BUBBLE_ADDR_DEF
) (
  input  logic                   clk1,
  input  logic                   rst_n,
  input  logic                   flush,
  alu_issue_queue_if.slave       bus,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic [15:0]            stall_cnt
);

  localparam instr_t BUBBLE_INSTR = '{func: BUBBLE_FUNC, rd: '0, rs1: '0, rs2: '0, addr: BUBBLE_ADDR};

  logic [INSTR_W-1:0] head_raw;
  instr_t             head;
  logic               fifo_full, fifo_empty;
  logic               push, pop, hazard, stall;

  logic [HAZ_WINDOW-1:0]            sb_v_q, sb_v_d;
  logic [HAZ_WINDOW-1:0][REG_W-1:0] sb_rd_q, sb_rd_d;

  instr_t      out_q, out_d;
  logic        issue_valid_q, issue_valid_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  assign head         = instr_t'(head_raw);
  assign bus.in_ready = !fifo_full;
  assign push         = bus.in_valid && !fifo_full && !flush;

  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < HAZ_WINDOW; i++) begin
      // R0 is the bubble target and never carries a real dependency.
      if (sb_v_q[i] && (sb_rd_q[i] != '0) &&
          ((sb_rd_q[i] == head.rs1) || (sb_rd_q[i] == head.rs2)))
        hazard = 1'b1;
    end
  end

  assign stall = !fifo_empty && hazard && !flush;
  assign pop   = !fifo_empty && !hazard && !flush;

  alu_instr_fifo #(
    .DEPTH(DEPTH),
    .W    (INSTR_W)
  ) u_fifo (
    .clk_i  (clk1),
    .rst_ni (rst_n),
    .push_i (push),
    .pop_i  (pop),
    .flush_i(flush),
    .wdata_i(bus.in_instr),
    .rdata_o(head_raw),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .count_o(occupancy)
  );

  always_comb begin
    out_d         = BUBBLE_INSTR;
    issue_valid_d = 1'b0;
    if (pop) begin
      out_d         = head;
      issue_valid_d = 1'b1;
    end

    // Shifts every edge; flush leaves in-flight producers in place.
    sb_v_d  = sb_v_q;
    sb_rd_d = sb_rd_q;
    for (int i = HAZ_WINDOW - 1; i > 0; i--) begin
      sb_v_d[i]  = sb_v_q[i-1];
      sb_rd_d[i] = sb_rd_q[i-1];
    end
    sb_v_d[0]  = pop;
    sb_rd_d[0] = pop ? head.rd : '0;

    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      out_q         <= BUBBLE_INSTR;
      issue_valid_q <= 1'b0;
      sb_v_q        <= '0;
      sb_rd_q       <= '0;
      stall_cnt_q   <= '0;
    end else begin
      out_q         <= out_d;
      issue_valid_q <= issue_valid_d;
      sb_v_q        <= sb_v_d;
      sb_rd_q       <= sb_rd_d;
      stall_cnt_q   <= stall_cnt_d;
    end
  end

  assign bus.rs1         = out_q.rs1;
  assign bus.rs2         = out_q.rs2;
  assign bus.rd          = out_q.rd;
  assign bus.func        = out_q.func;
  assign bus.addr        = out_q.addr;
  assign bus.issue_valid = issue_valid_q;
  assign stall_cnt       = stall_cnt_q;

endmodule

// File: tb/tb_alu_issue_queue.sv
// tb/tb_alu_issue_queue.sv - scoreboard bench for alu_issue_queue
module tb_alu_issue_queue;

  logic        clk1  = 1'b0;
  logic        rst_n = 1'b1;
  logic        flush = 1'b0;
  logic [2:0]  occupancy;
  logic [15:0] stall_cnt;

  alu_issue_queue_if bus ();

  alu_issue_queue #(
    .DEPTH      (4),
    .HAZ_WINDOW (3),
    .BUBBLE_FUNC(4'hF),
    .BUBBLE_ADDR(8'hFF)
  ) dut (
    .clk1     (clk1),
    .rst_n    (rst_n),
    .flush    (flush),
    .bus      (bus),
    .occupancy(occupancy),
    .stall_cnt(stall_cnt)
  );

  always #5 clk1 = ~clk1;

  typedef struct {
    logic [23:0] instr;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always @(posedge clk1) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected edge is the push edge plus a hand-computed issue delay; delta 0 means the entry must never issue.
  task automatic push(input logic [23:0] ins, input int delta);
    exp_t e;
    bus.in_valid = 1'b1;
    bus.in_instr = ins;
    @(posedge clk1);
    #1;
    if (delta > 0) begin
      e.instr = ins;
      e.cyc   = cyc + delta;
      exp_q.push_back(e);
    end
    bus.in_valid = 1'b0;
    bus.in_instr = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk1);
      #1;
    end
  endtask

  always @(negedge clk1) begin
    if (rst_n) begin
      if (bus.issue_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_issue: got %0h expected no issue (edge %0d)",
                   {bus.func, bus.rd, bus.rs1, bus.rs2, bus.addr}, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          check("issue_fields", {8'h0, bus.func, bus.rd, bus.rs1, bus.rs2, bus.addr}, {8'h0, mon_e.instr});
          check("issue_edge", cyc, mon_e.cyc);
        end
      end else begin
        check("bubble_fields", {8'h0, bus.func, bus.rd, bus.rs1, bus.rs2, bus.addr},
              {8'h0, 4'hF, 4'h0, 4'h0, 4'h0, 8'hFF});
      end
    end
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_instr = '0;
    #1 rst_n = 1'b0;

    // Reset and idle
    repeat (3) @(posedge clk1);
    #1;
    check("rst_issue_valid", bus.issue_valid, 0);
    check("rst_func", bus.func, 4'hF);
    check("rst_addr", bus.addr, 8'hFF);
    check("rst_rd", bus.rd, 0);
    check("rst_stall_cnt", stall_cnt, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk1);
      #1;
      check("idle_in_ready", bus.in_ready, 1);
      check("idle_occupancy", occupancy, 0);
      check("idle_issue_valid", bus.issue_valid, 0);
    end

    // Independent back-to-back stream
    push(24'h13A50A, 1);
    push(24'h24CF14, 1);
    push(24'h31F11E, 1);
    idle(6);
    check("indep_stall_cnt", stall_cnt, 0);
    check("indep_occupancy", occupancy, 0);

    // RAW on R3: three bubbles
    push(24'h13A50A, 1);
    push(24'h243314, 4);
    idle(8);
    check("raw_stall_cnt", stall_cnt, 3);

    // Fill behind a chain on R5, then offer a fifth entry
    push(24'h150000, 1);
    push(24'h255501, 4);
    push(24'h255502, 7);
    push(24'h255503, 10);
    push(24'h255504, 13);
    check("full_occupancy", occupancy, 4);
    check("full_in_ready", bus.in_ready, 0);
    bus.in_valid = 1'b1;
    bus.in_instr = 24'h360055;
    @(posedge clk1);
    #1;
    check("after_pop_occupancy", occupancy, 3);
    check("after_pop_in_ready", bus.in_ready, 1);
    push(24'h360055, 12);
    idle(16);
    check("full_stall_cnt", stall_cnt, 15);
    check("full_drained", occupancy, 0);

    // Flush with R7 producer still in the window
    push(24'h160060, 1);
    push(24'h176070, 4);
    push(24'h287001, 0);
    push(24'h297002, 0);
    push(24'h2A7003, 0);
    idle(1);
    check("preflush_occupancy", occupancy, 3);
    check("preflush_stall_cnt", stall_cnt, 18);
    flush        = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_instr = 24'h4BCD44;
    @(posedge clk1);
    #1;
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    check("flush_occupancy", occupancy, 0);
    check("flush_in_ready", bus.in_ready, 1);
    check("flush_stall_held", stall_cnt, 18);
    push(24'h5C7777, 2);
    idle(6);
    check("postflush_stall_cnt", stall_cnt, 19);

    // Reset to clear counters, then build stall_cnt=5 with two queued
    rst_n = 1'b0;
    #1;
    check("rst2_stall_cnt", stall_cnt, 0);
    @(posedge clk1);
    #1;
    rst_n = 1'b1;
    push(24'h1100A1, 1);
    push(24'h2210B2, 4);
    push(24'h3320C3, 0);
    push(24'h4400D4, 0);
    idle(4);
    check("pre_async_occupancy", occupancy, 2);
    check("pre_async_stall_cnt", stall_cnt, 5);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_issue_valid", bus.issue_valid, 0);
    check("async_func", bus.func, 4'hF);
    check("async_addr", bus.addr, 8'hFF);
    check("async_rd", bus.rd, 0);
    check("async_stall_cnt", stall_cnt, 0);
    check("async_occupancy", occupancy, 0);
    check("async_in_ready", bus.in_ready, 1);
    @(posedge clk1);
    #1;
    rst_n = 1'b1;
    idle(8);
    check("post_async_occupancy", occupancy, 0);

    check("exp_queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_issue_queue.md
Name: alu_issue_queue

Overview:
- Upstream neighbour of pipeline_alu.
- Buffers packed ALU instructions from the fetch/decode side in a small FIFO and detects read-after-write hazards against recently issued destinations.
- Drives pipeline_alu's rs1/rs2/rd/func/addr inputs one instruction per clock, inserting bubbles while a hazard exists.
- pipeline_alu has no valid input, so this block is solely responsible for hazard-free ordering.

Parameters:
- DEPTH, 4: FIFO entries; power of two, at least 2.
- HAZ_WINDOW, 3: cycles after issue during which the issued rd blocks dependent reads.
- BUBBLE_FUNC, 4'hF: func value driven on bubble cycles.
- BUBBLE_ADDR, 8'hFF: addr value driven on bubble cycles.

Ports:
- clk1  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  in_instr is valid.
- in_ready  out  1  queue can accept.
- in_instr  in  24  packed instruction: {func[23:20], rd[19:16], rs1[15:12], rs2[11:8], addr[7:0]}.
- flush  in  1  synchronous discard of all queued entries.
- rs1  out  4  source register 1 to pipeline_alu.
- rs2  out  4  source register 2.
- rd  out  4  destination register.
- func  out  4  ALU opcode.
- addr  out  8  store address.
- issue_valid  out  1  outputs carry a real instruction this cycle.
- occupancy  out  clog2(DEPTH)+1  current entry count.
- stall_cnt  out  16  hazard-stall cycle count, saturating.

Behaviour:
- Reset (async assert, sync release):
  - FIFO empty, occupancy=0, in_ready=1.
  - Scoreboard cleared.
  - stall_cnt=0, issue_valid=0.
  - Outputs in bubble state: rs1=rs2=rd=0, func=BUBBLE_FUNC, addr=BUBBLE_ADDR.
  - Reset mid-stream drops all queued entries; nothing is replayed.
- Push: accepted on an edge where in_valid && in_ready.
  - in_ready = (occupancy != DEPTH), combinational from registered occupancy only.
  - When full, no push even if a pop occurs on the same edge.
- Scoreboard: HAZ_WINDOW-deep shift register of {v, rd}.
  - Shifts every edge.
  - Inserts {1, rd} on issue and {0, 0} on bubble.
- Hazard: head entry non-empty and (head.rs1 or head.rs2) equals the rd of any scoreboard entry with v=1 and rd != 0.
  - R0 is a scratch/bubble target and never creates a hazard.
  - Evaluated on pre-edge state.
- Issue on each edge:
  - If non-empty and no hazard: pop head, register its fields onto the outputs, issue_valid=1.
  - Otherwise: outputs take bubble values, issue_valid=0.
  - All outputs are registered; no combinational path from in_* to outputs.
- Latency:
  - An entry pushed at edge N into an empty, hazard-free queue is earliest issued at edge N+1.
  - Its fields are visible on the outputs after edge N+1.
  - A dependent instruction issues exactly HAZ_WINDOW+1 edges after its producer, leaving HAZ_WINDOW bubbles between them.
- stall_cnt: +1 on each edge where the queue is non-empty and a hazard exists; holds at 16'hFFFF.
- Simultaneous push and pop (not full): both take effect; occupancy is unchanged.
- Pointers wrap modulo DEPTH.
- flush:
  - Empties the FIFO, and that edge drives a bubble.
  - Flush wins over push on the same edge.
  - Scoreboard is not cleared, because issued instructions are still in flight.
  - stall_cnt is held.

Decomposition:
- Package alu_pipe_pkg holds:
  - Field widths: REG_W=4, FUNC_W=4, ADDR_W=8, INSTR_W=24.
  - in_instr bit-slice positions.
  - Bubble defaults.
- Sub-module alu_instr_fifo: generic DEPTH x INSTR_W FIFO with push/pop/flush, full/empty and occupancy.
- Top-level logic: hazard check, scoreboard, output registers and stall counter.

Test Plan:
- Reset/idle:
  - Stimulus: hold rst_n=0, release, then 5 idle cycles.
  - Response: issue_valid=0, func=4'hF, addr=8'hFF, rd=0, in_ready=1, occupancy=0 throughout.
- Independent stream:
  - Stimulus: push {1,3,A,5,0A}, {2,4,C,F,14}, {3,1,F,1,1E} on consecutive edges.
  - Response: three back-to-back issues starting one edge after the first push; Z-path fields match in order; stall_cnt=0.
- RAW hazard:
  - Stimulus: push {1,3,A,5,0A} then {2,4,3,3,14}.
  - Response: second issues 4 edges after first, with 3 bubbles between; stall_cnt=3.
- Full/backpressure:
  - Stimulus: enqueue 4 mutually dependent entries on R5 while the first is stalled, then offer a 5th.
  - Response: in_ready=0 at occupancy=4; 5th accepted only after a pop; no entry lost or duplicated.
- Flush:
  - Stimulus: with 3 queued and one issued with rd=7, assert flush alongside a push.
  - Response: occupancy=0 next edge; pushed entry dropped; a later push reading R7 still stalls the remaining window.
- Async reset mid-stream:
  - Stimulus: assert rst_n=0 between clock edges with 2 entries queued and stall_cnt=5.
  - Response: outputs go to bubble immediately, with stall_cnt=0 and occupancy=0 before the next edge.
